// File: rtl/compare_sequencer.sv
// rtl/compare_sequencer.sv - operand/result handshake wrapper around the serial magnitude comparator.
// Optional saturating result counters are enabled with `define CMP_SEQ_STATS_EN.
module compare_sequencer #(
    parameter int WIDTH       = 4,
    parameter int WAIT_CYCLES = WIDTH + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             cmp_reset,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_lt,
    output logic             out_eq,
    output logic             out_gt,
    output logic             out_err
`ifdef CMP_SEQ_STATS_EN
    ,
    output logic [15:0]      cnt_lt,
    output logic [15:0]      cnt_eq,
    output logic [15:0]      cnt_gt,
    output logic [15:0]      cnt_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             cmp_reset_q, cmp_reset_d;
    logic             valid_q, valid_d;
    logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d, err_q, err_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = 8'(WAIT_CYCLES - 1);
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == 8'd0) begin
                    lt_d    = cmp_lt;
                    eq_d    = cmp_eq;
                    gt_d    = cmp_gt;
                    err_d   = !(({cmp_lt, cmp_eq, cmp_gt} == 3'b100) ||
                                ({cmp_lt, cmp_eq, cmp_gt} == 3'b010) ||
                                ({cmp_lt, cmp_eq, cmp_gt} == 3'b001));
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registered clear: high for the single cycle the FSM sits in CLEAR.
        cmp_reset_d = (state_d == S_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= 8'd0;
            cmp_reset_q <= 1'b1;
            valid_q     <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            cmp_reset_q <= cmp_reset_d;
            valid_q     <= valid_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign cmp_reset = cmp_reset_q;
    assign cmp_a     = a_q;
    assign cmp_b     = b_q;
    assign out_valid = valid_q;
    assign out_lt    = lt_q;
    assign out_eq    = eq_q;
    assign out_gt    = gt_q;
    assign out_err   = err_q;

`ifdef CMP_SEQ_STATS_EN
    logic [15:0] cnt_lt_q, cnt_eq_q, cnt_gt_q, cnt_err_q;
    logic        deliver;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    assign deliver = valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_lt_q  <= 16'd0;
            cnt_eq_q  <= 16'd0;
            cnt_gt_q  <= 16'd0;
            cnt_err_q <= 16'd0;
        end else begin
            cnt_lt_q  <= sat_inc(cnt_lt_q,  deliver && lt_q);
            cnt_eq_q  <= sat_inc(cnt_eq_q,  deliver && eq_q);
            cnt_gt_q  <= sat_inc(cnt_gt_q,  deliver && gt_q);
            cnt_err_q <= sat_inc(cnt_err_q, deliver && err_q);
        end
    end

    assign cnt_lt  = cnt_lt_q;
    assign cnt_eq  = cnt_eq_q;
    assign cnt_gt  = cnt_gt_q;
    assign cnt_err = cnt_err_q;
`endif

endmodule

// File: tb/tb_compare_sequencer.sv
// tb/tb_compare_sequencer.sv - randomized self-checking bench for compare_sequencer against a behavioural model.
module tb_compare_sequencer;
    localparam int WIDTH = 4;
    localparam int WAIT  = WIDTH + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_a, in_b, cmp_a, cmp_b;
    logic             cmp_reset, cmp_lt, cmp_eq, cmp_gt;
    logic             out_valid, out_ready, out_lt, out_eq, out_gt, out_err;
`ifdef CMP_SEQ_STATS_EN
    logic [15:0]      cnt_lt, cnt_eq, cnt_gt, cnt_err;
`endif

    int total = 0;
    int bad   = 0;
    int inj   = 0;
    int exp_lt_n = 0, exp_eq_n = 0, exp_gt_n = 0, exp_err_n = 0;

    compare_sequencer #(.WIDTH(WIDTH), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .cmp_reset(cmp_reset), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lt(out_lt), .out_eq(out_eq), .out_gt(out_gt), .out_err(out_err)
`ifdef CMP_SEQ_STATS_EN
        , .cnt_lt(cnt_lt), .cnt_eq(cnt_eq), .cnt_gt(cnt_gt), .cnt_err(cnt_err)
`endif
    );

    always #5 clk = ~clk;

    // Comparator model: flags idle low while cleared; inj selects a faulty flag pattern.
    always_comb begin
        cmp_lt = 1'b0;
        cmp_eq = 1'b0;
        cmp_gt = 1'b0;
        if (!cmp_reset) begin
            case (inj)
                0: begin
                    cmp_lt = cmp_a < cmp_b;
                    cmp_eq = cmp_a == cmp_b;
                    cmp_gt = cmp_a > cmp_b;
                end
                1: begin
                    cmp_lt = 1'b1;
                    cmp_gt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_cmp_reset", 32'(cmp_reset), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_cmp_ab", {24'd0, cmp_a, cmp_b}, 32'd0);
        check("rst_flags", {28'd0, out_lt, out_eq, out_gt, out_err}, 32'd0);
        reset = 1'b0;
        exp_lt_n = 0; exp_eq_n = 0; exp_gt_n = 0; exp_err_n = 0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // One full transaction; hold = cycles of backpressure, bp_next keeps a new pair offered meanwhile.
    task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input int mode,
                           input int hold, input logic bp_next, input logic [3:0] na, input logic [3:0] nb);
        int  lat, crst, to;
        logic el, ee, eg, er, ab_ok, st_ok, rdy_ok;
        logic [3:0] fl;
        case (mode)
            0:       begin el = a < b; ee = a == b; eg = a > b; end
            1:       begin el = 1'b1; ee = 1'b0; eg = 1'b1; end
            default: begin el = 1'b0; ee = 1'b0; eg = 1'b0; end
        endcase
        er  = (int'(el) + int'(ee) + int'(eg)) != 1;
        inj = mode;
        to  = 0;
        while (!in_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        check("accept_timeout", 32'(to < 50), 32'd1);
        in_valid = 1'b1; in_a = a; in_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_a = 4'($urandom); in_b = 4'($urandom);
        lat = 0; crst = 0; ab_ok = 1'b1;
        while (!out_valid && lat < 300) begin
            if (cmp_reset) crst++;
            if (cmp_a != a || cmp_b != b) ab_ok = 1'b0;
            if (lat > 0 && in_ready) ab_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(WAIT + 1));
        check("clear_pulses", 32'(crst), 32'd1);
        check("operands_held", 32'(ab_ok), 32'd1);
        fl = {out_lt, out_eq, out_gt, out_err};
        check("flags", 32'(fl), 32'({el, ee, eg, er}));
        out_ready = 1'b0;
        st_ok = 1'b1; rdy_ok = 1'b1;
        if (bp_next) begin
            in_valid = 1'b1; in_a = na; in_b = nb;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if ({out_lt, out_eq, out_gt, out_err} != fl || !out_valid) st_ok = 1'b0;
            if (in_ready || cmp_a != a || cmp_b != b) rdy_ok = 1'b0;
        end
        check("hold_stable", 32'(st_ok), 32'd1);
        check("hold_no_ready", 32'(rdy_ok), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_lt_n += int'(el); exp_eq_n += int'(ee); exp_gt_n += int'(eg); exp_err_n += int'(er);
        check("valid_drop", 32'(out_valid), 32'd0);
        check("ready_after_hs", 32'(in_ready), 32'd1);
        if (bp_next) check("not_yet_accepted", {24'd0, cmp_a, cmp_b}, {24'd0, a, b});
    endtask

`ifdef CMP_SEQ_STATS_EN
    task automatic check_stats(input string tag);
        check({tag, "_lt"},  32'(cnt_lt),  32'(exp_lt_n));
        check({tag, "_eq"},  32'(cnt_eq),  32'(exp_eq_n));
        check({tag, "_gt"},  32'(cnt_gt),  32'(exp_gt_n));
        check({tag, "_err"}, 32'(cnt_err), 32'(exp_err_n));
    endtask
`endif

    initial begin
        int seen;
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        do_reset(2);

        run_txn(4'd9, 4'd3, 0, 0, 1'b0, 4'd0, 4'd0);
        run_txn(4'hA, 4'hA, 0, 1, 1'b0, 4'd0, 4'd0);
        run_txn(4'd2, 4'd13, 0, 2, 1'b0, 4'd0, 4'd0);
        run_txn(4'd7, 4'd1, 0, 10, 1'b1, 4'd5, 4'd6);
        run_txn(4'd5, 4'd6, 0, 0, 1'b0, 4'd0, 4'd0);
        run_txn(4'd4, 4'd8, 1, 3, 1'b0, 4'd0, 4'd0);

        for (int i = 0; i < 20; i++)
            run_txn(4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0) ? 1 : 0,
                    $urandom_range(0, 3), 1'b0, 4'd0, 4'd0);

        // Abandon a compare mid-RUN, when the wait counter reads 2.
        inj = 0;
        in_valid = 1'b1; in_a = 4'd12; in_b = 4'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (WAIT - 2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_cmp_ab", {24'd0, cmp_a, cmp_b}, 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        exp_lt_n = 0; exp_eq_n = 0; exp_gt_n = 0; exp_err_n = 0;
        @(posedge clk);
        #1;
        check("abort_idle", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);

`ifdef CMP_SEQ_STATS_EN
        do_reset(1);
        check_stats("stats_rst");
        for (int i = 0; i < 3; i++) run_txn(4'd9, 4'd2, 0, 0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 2; i++) run_txn(4'd6, 4'd6, 0, 1, 1'b0, 4'd0, 4'd0);
        run_txn(4'd1, 4'd1, 2, 0, 1'b0, 4'd0, 4'd0);
        check_stats("stats_run");
        check("stats_gt_three", 32'(cnt_gt), 32'd3);
        do_reset(1);
        check_stats("stats_clr");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/compare_sequencer.md
Name: compare_sequencer

Overview:
- Upstream/downstream wrapper for the serial magnitude comparator stage.
- Accepts operand pairs over a valid/ready input handshake and drives them, held stable, into the comparator.
- Pulses the comparator's clear line, waits a fixed settle window, captures the one-hot lt/eq/gt flags, and returns them over a valid/ready output handshake.
- Processes one compare at a time (non-pipelined).

Parameters:
- WIDTH, 4, operand width in bits (comparator n = WIDTH-1).
- WAIT_CYCLES, WIDTH+2, cycles in RUN after the clear pulse before flags are sampled; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- cmp_reset  out  1  clear pulse to the comparator.
- cmp_a  out  WIDTH  operand A held to the comparator.
- cmp_b  out  WIDTH  operand B held to the comparator.
- cmp_lt  in  1  comparator less_than.
- cmp_eq  in  1  comparator equal_to.
- cmp_gt  in  1  comparator greater_than.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_lt  out  1  captured A<B.
- out_eq  out  1  captured A==B.
- out_gt  out  1  captured A>B.
- out_err  out  1  captured flags not one-hot.

Behaviour:
- Reset values:
  - state=IDLE; in_ready=0 during the reset cycle, 1 from the first cycle after reset.
  - cmp_reset=1 while reset is high.
  - cmp_a=cmp_b=0.
  - out_valid=0; out_lt/eq/gt/err=0; wait counter=0.
- Reset has priority over everything; asserting it mid-operation abandons the compare with no result.
- IDLE:
  - in_ready=1 (combinational from state).
  - On in_valid&in_ready, register in_a/in_b into cmp_a/cmp_b and go to CLEAR.
- CLEAR (exactly 1 cycle):
  - cmp_reset=1; cmp_a/cmp_b hold.
  - Load counter with WAIT_CYCLES-1; go to RUN.
- RUN:
  - cmp_reset=0; cmp_a/cmp_b hold; counter decrements each cycle.
  - On the cycle the counter reads 0, sample cmp_lt/eq/gt into out_lt/eq/gt.
  - out_err = NOT exactly-one-of(lt,eq,gt).
  - Set out_valid=1 and go to HOLD.
- HOLD:
  - out_valid=1; outputs stable until out_ready.
  - On out_ready, clear out_valid and go to IDLE. in_ready rises the following cycle (no same-cycle turnaround).
- Latency: input accept edge to out_valid = 1 (CLEAR) + WAIT_CYCLES cycles.
- Maximum throughput: one result per WAIT_CYCLES+3 cycles.
- in_valid while in_ready=0 is ignored; the upstream producer holds its data.
- cmp_a/cmp_b change only on the accept edge; they are never modified during CLEAR, RUN or HOLD.
- out_err does not block the flow; the result is delivered normally with err=1.
- cmp_reset is a registered output: high exactly during reset and in CLEAR.

Optional Feature:
- Macro CMP_SEQ_STATS_EN.
- Defined:
  - Adds outputs cnt_lt, cnt_eq, cnt_gt, cnt_err, each 16 bits.
  - Each increments on the out_valid&out_ready edge according to the delivered flags.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic compares: reset 2 cycles, then send a=4'd9, b=4'd3 with a model comparator → out_valid exactly 1+WAIT_CYCLES=7 cycles after accept; out_gt=1, out_lt=0, out_eq=0, out_err=0.
- Equal and less: send a=b=4'hA, then a=4'd2, b=4'd13 → results eq=1, then lt=1; cmp_reset high exactly one cycle per transaction.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD while in_valid=1 with a new pair → flags stable, in_ready=0 throughout, second pair accepted only in the cycle after the out_ready handshake.
- Error detection: force the model to drive cmp_lt=1 and cmp_gt=1 at sample time → out_err=1, with out_lt=1 and out_gt=1 reported as captured.
- Mid-operation reset: assert reset during RUN at counter=2 → next cycle state=IDLE, out_valid=0, cmp_a=cmp_b=0; no result ever delivered for the abandoned pair.
- Stats (CMP_SEQ_STATS_EN): deliver 3 gt, 2 eq and 1 err result → cnt_gt=3, cnt_eq=2, cnt_err=1; reset then returns all counters to 0.
